alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Sequences the 4-bit arithmetic datapath: it accepts a 10-bit op word {ain[3:0], bin[3:0], func[1:0]}
//  through a valid/ready handshake and runs it over one 2x2 multiplier and one 4-bit adder.
//  Multiply-add (func=3) time-shares the single multiplier across two cycles.
//  It returns a 5-bit result through a second valid/ready handshake and sits between the op source and the result sink.
// PARAMETERS
//  CNT_W       8   width of op_count (completed-op counter, wraps)
//  MAC_SHARED  1   1: func=3 takes 2 exec cycles on one multiplier; 0: 1 exec cycle, two multipliers
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  instr        in   10  op word: [9:6]=ain, [5:2]=bin, [1:0]=func
//  instr_valid  in   1   instr is valid
//  instr_ready  out  1   block can accept instr this cycle
//  result       out  5   zero-extended result
//  res_func     out  2   func of the op that produced result
//  res_valid    out  1   result/res_func valid
//  res_ready    in   1   sink accepts result this cycle
//  busy         out  1   high in any state other than IDLE
//  op_count     out  CNT_W  number of results handed off, modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; result=0, res_func=0, res_valid=0, busy=0, op_count=0, operand regs=0.
//   Any op in flight is dropped; no partial result is ever presented.
//  FSM states: IDLE, EX1, EX2, OUT.
//   IDLE: instr_ready=1. On instr_valid & instr_ready, latch ain/bin/func and go to EX1.
//   EX1: func=0: result<=ain+bin (carry in bit 4), go to OUT.
//        func=1: result<=ain[3:2]*ain[1:0] (0..9), go to OUT.
//        func=2: result<=popcount(ain&bin) (0..4), go to OUT.
//        func=3, MAC_SHARED=1: partial<=ain[3:2]*ain[1:0], go to EX2.
//        func=3, MAC_SHARED=0: result<=ain[3:2]*ain[1:0]+bin[3:2]*bin[1:0], go to OUT.
//   EX2: result<=partial+bin[3:2]*bin[1:0] (max 18, fits 5 bits), go to OUT.
//   OUT: res_valid=1; result and res_func held stable while res_ready=0.
//        On res_ready: op_count<=op_count+1 (wraps to 0), go to IDLE.
//  instr_ready=0 in EX1/EX2/OUT, so one op is in flight at a time. The first new op can be accepted on the
//   edge after the handoff, at the earliest.
//  Latency, counted from the acceptance edge (E0):
//   - res_valid rises after E1 for func 0/1/2, and for func 3 with MAC_SHARED=0.
//   - res_valid rises after E2 for func 3 with MAC_SHARED=1.
//  res_func is registered together with result. res_valid deasserts on the edge where res_ready is sampled high.
//  instr is ignored when instr_ready=0, and X on instr is don't-care when instr_valid=0.
//  All arithmetic is unsigned. No overflow is possible: the maximum result is 30 (func 0) and 18 (func 3).
//  Reset asserted in EX1/EX2/OUT forces IDLE immediately; op_count is not incremented for the dropped op.
//  All outputs are registered, except instr_ready and busy, which are decoded from state only.
// TESTING
//  T1 add: instr=1111_0001_00 -> result=16, res_func=0, res_valid 1 edge after accept; op_count 0->1 on handoff.
//  T2 mult/dot: 1110_0000_01 -> result=6; then 1011_1110_10 -> result=2; back-to-back ops with res_ready=1 tied high.
//  T3 mac: 1111_1010_11 with MAC_SHARED=1 -> result=13 after 2 edges, busy high through EX1 and EX2;
//      MAC_SHARED=0 -> result=13 after 1 edge; max case 1111_1111_11 -> 18.
//  T4 backpressure: res_ready=0 for 5 cycles after res_valid -> result/res_func constant, instr_ready=0,
//      a new instr_valid is not accepted; res_ready=1 -> handoff, IDLE next cycle.
//  T5 reset mid-op: assert rst_n=0 asynchronously while in EX2 -> outputs 0 and busy=0 with no clock edge;
//      after release a fresh op completes normally and op_count starts from 0.
//  T6 counter wrap: CNT_W=2, complete 5 ops -> op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one 10-bit op word at a time, runs it over a 2x2
// multiplier / 4-bit adder datapath and hands back a 5-bit result.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr[9:0], instr_valid    op word {ain, bin, func} and its valid
//   instr_ready                high in IDLE only (decoded from state)
//   result[4:0], res_func[1:0] registered result and the func that produced it
//   res_valid, res_ready       result handshake
//   busy                       high in any state other than IDLE (decoded)
//   op_count[CNT_W-1:0]        completed handoffs, wrapping
module alu_op_sequencer #(
    parameter int unsigned CNT_W      = 8,
    parameter bit          MAC_SHARED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [4:0]       result,
    output logic [1:0]       res_func,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned OPND_W = 4;
    localparam int unsigned FUNC_W = 2;
    localparam int unsigned RES_W  = 5;

    typedef struct packed {
        logic [OPND_W-1:0] ain;
        logic [OPND_W-1:0] bin;
        logic [FUNC_W-1:0] func;
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EX1  = 2'd1,
        EX2  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [OPND_W-1:0]  partial_q, partial_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic [FUNC_W-1:0]  res_func_q, res_func_d;
    logic               res_valid_q, res_valid_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    // Product of the two 2-bit halves of a 4-bit operand (0..9).
    function automatic logic [OPND_W-1:0] mul_halves(input logic [OPND_W-1:0] x);
        return {2'b00, x[3:2]} * {2'b00, x[1:0]};
    endfunction

    // Number of set bits in a 4-bit value (0..4).
    function automatic logic [2:0] popcnt4(input logic [OPND_W-1:0] m);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            c = c + 3'(m[i]);
        end
        return c;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            partial_q   <= '0;
            result_q    <= '0;
            res_func_q  <= '0;
            res_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            partial_q   <= partial_d;
            result_q    <= result_d;
            res_func_q  <= res_func_d;
            res_valid_q <= res_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    // Next-state and next-register-value decode.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        partial_d   = partial_q;
        result_d    = result_q;
        res_func_d  = res_func_q;
        res_valid_d = res_valid_q;
        op_count_d  = op_count_q;

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    op_d    = op_t'(instr);
                    state_d = EX1;
                end
            end
            EX1: begin
                state_d     = OUT;
                res_valid_d = 1'b1;
                res_func_d  = op_q.func;
                case (op_q.func)
                    2'd0: result_d = RES_W'(op_q.ain) + RES_W'(op_q.bin);
                    2'd1: result_d = RES_W'(mul_halves(op_q.ain));
                    2'd2: result_d = RES_W'(popcnt4(op_q.ain & op_q.bin));
                    2'd3: begin
                        if (MAC_SHARED) begin
                            // Single multiplier: first product now, second in EX2.
                            partial_d   = mul_halves(op_q.ain);
                            state_d     = EX2;
                            res_valid_d = 1'b0;
                            res_func_d  = res_func_q;
                        end else begin
                            result_d = RES_W'(mul_halves(op_q.ain))
                                     + RES_W'(mul_halves(op_q.bin));
                        end
                    end
                    default: ;
                endcase
            end
            EX2: begin
                result_d    = RES_W'(partial_q) + RES_W'(mul_halves(op_q.bin));
                res_func_d  = op_q.func;
                res_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign result      = result_q;
    assign res_func    = res_func_q;
    assign res_valid   = res_valid_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer. Three instances: index 0 shared MAC (CNT_W=8),
// index 1 dual-multiplier MAC (CNT_W=8), index 2 shared MAC with CNT_W=2.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] instr       [3];
    logic       instr_valid [3];
    logic       instr_ready [3];
    logic [4:0] result      [3];
    logic [1:0] res_func    [3];
    logic       res_valid   [3];
    logic       res_ready   [3];
    logic       busy        [3];
    logic [7:0] oc0, oc1;
    logic [1:0] oc2;

    int tests = 0;
    int fails = 0;
    int exp_cnt [3];

    always #5 clk = ~clk;

    alu_op_sequencer #(.CNT_W(8), .MAC_SHARED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr[0]), .instr_valid(instr_valid[0]),
        .instr_ready(instr_ready[0]), .result(result[0]), .res_func(res_func[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .busy(busy[0]), .op_count(oc0)
    );

    alu_op_sequencer #(.CNT_W(8), .MAC_SHARED(1'b0)) dut_dual (
        .clk(clk), .rst_n(rst_n), .instr(instr[1]), .instr_valid(instr_valid[1]),
        .instr_ready(instr_ready[1]), .result(result[1]), .res_func(res_func[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .busy(busy[1]), .op_count(oc1)
    );

    alu_op_sequencer #(.CNT_W(2), .MAC_SHARED(1'b1)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .instr(instr[2]), .instr_valid(instr_valid[2]),
        .instr_ready(instr_ready[2]), .result(result[2]), .res_func(res_func[2]),
        .res_valid(res_valid[2]), .res_ready(res_ready[2]), .busy(busy[2]), .op_count(oc2)
    );

    typedef struct {
        int         k;
        logic [9:0] word;
        int         exp_res;
        int         hold;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int k);
        case (k)
            0:       return int'(oc0);
            1:       return int'(oc1);
            default: return int'(oc2);
        endcase
    endfunction

    function automatic int cnt_mod(input int k);
        return (k == 2) ? 4 : 256;
    endfunction

    // Reference result straight from the op definitions.
    function automatic int ref_result(input int a, input int b, input int f);
        int pc;
        case (f)
            0: return a + b;
            1: return (a / 4) * (a % 4);
            2: begin
                pc = 0;
                for (int i = 0; i < 4; i++) if (((a & b) >> i) % 2 == 1) pc++;
                return pc;
            end
            default: return (a / 4) * (a % 4) + (b / 4) * (b % 4);
        endcase
    endfunction

    // Issue one op on instance k, optionally stall the sink for 'hold' cycles,
    // and check latency, result, stability and the handoff count.
    task automatic run_op(input int k, input int a, input int b, input int f,
                          input int hold, input int exp_res);
        int lat;
        int cyc;
        lat = (f == 3 && k != 1) ? 2 : 1;
        check("instr_ready_idle", int'(instr_ready[k]), 1);
        instr[k]       = {4'(a), 4'(b), 2'(f)};
        instr_valid[k] = 1'b1;
        res_ready[k]   = (hold == 0);
        @(negedge clk);
        instr_valid[k] = 1'b0;
        instr[k]       = 10'($urandom);
        cyc = 0;
        do begin
            check("busy_exec", int'(busy[k]), 1);
            check("instr_ready_exec", int'(instr_ready[k]), 0);
            @(negedge clk);
            cyc++;
        end while (!res_valid[k] && cyc < 8);
        check("latency", cyc, lat);
        check("result", int'(result[k]), exp_res);
        check("res_func", int'(res_func[k]), f);
        for (int h = 0; h < hold; h++) begin
            instr_valid[k] = 1'b1;
            instr[k]       = 10'($urandom);
            @(negedge clk);
            check("hold_valid", int'(res_valid[k]), 1);
            check("hold_result", int'(result[k]), exp_res);
            check("hold_func", int'(res_func[k]), f);
            check("hold_instr_ready", int'(instr_ready[k]), 0);
        end
        instr_valid[k] = 1'b0;
        res_ready[k]   = 1'b1;
        @(negedge clk);
        exp_cnt[k] = (exp_cnt[k] + 1) % cnt_mod(k);
        check("valid_after_handoff", int'(res_valid[k]), 0);
        check("busy_after_handoff", int'(busy[k]), 0);
        check("op_count", cnt_of(k), exp_cnt[k]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        int   seq  [5];
        int   a, b, f, k, hold;

        vecs[0] = '{0, 10'b1111_0001_00, 16, 0};
        vecs[1] = '{0, 10'b1110_0000_01,  6, 0};
        vecs[2] = '{0, 10'b1011_1110_10,  2, 0};
        vecs[3] = '{0, 10'b1111_1010_11, 13, 0};
        vecs[4] = '{1, 10'b1111_1010_11, 13, 0};
        vecs[5] = '{0, 10'b1111_1111_11, 18, 0};
        vecs[6] = '{1, 10'b1111_1111_11, 18, 0};
        vecs[7] = '{0, 10'b0110_0111_00, 13, 5};
        vecs[8] = '{1, 10'b1101_0000_01,  3, 2};
        vecs[9] = '{0, 10'b1111_1111_10,  4, 0};
        seq     = '{1, 2, 3, 0, 1};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instr[i]       = '0;
            instr_valid[i] = 1'b0;
            res_ready[i]   = 1'b0;
            exp_cnt[i]     = 0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_result", int'(result[i]), 0);
            check("rst_res_func", int'(res_func[i]), 0);
            check("rst_res_valid", int'(res_valid[i]), 0);
            check("rst_busy", int'(busy[i]), 0);
            check("rst_instr_ready", int'(instr_ready[i]), 1);
            check("rst_op_count", cnt_of(i), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table: add, mult, dot, MAC both variants, backpressure.
        for (int i = 0; i < 10; i++) begin
            a = int'(vecs[i].word[9:6]);
            b = int'(vecs[i].word[5:2]);
            f = int'(vecs[i].word[1:0]);
            run_op(vecs[i].k, a, b, f, vecs[i].hold, vecs[i].exp_res);
        end

        // Randomized ops against the reference model.
        for (int i = 0; i < 80; i++) begin
            k    = int'($urandom_range(0, 1));
            a    = int'($urandom_range(0, 15));
            b    = int'($urandom_range(0, 15));
            f    = int'($urandom_range(0, 3));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(k, a, b, f, hold, ref_result(a, b, f));
        end

        // Counter wrap on the 2-bit instance.
        for (int i = 0; i < 5; i++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            f = int'($urandom_range(0, 3));
            run_op(2, a, b, f, 0, ref_result(a, b, f));
            check("wrap_seq", cnt_of(2), seq[i]);
        end

        // Leave a nonzero result on instance 0, then reset in the middle of a MAC.
        run_op(0, 15, 10, 3, 0, 13);
        instr[0]       = {4'd15, 4'd15, 2'd3};
        instr_valid[0] = 1'b1;
        @(negedge clk);
        instr_valid[0] = 1'b0;
        @(negedge clk);
        check("ex2_busy", int'(busy[0]), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_result", int'(result[0]), 0);
        check("async_rst_res_func", int'(res_func[0]), 0);
        check("async_rst_res_valid", int'(res_valid[0]), 0);
        check("async_rst_busy", int'(busy[0]), 0);
        check("async_rst_op_count", cnt_of(0), 0);
        check("async_rst_op_count_w2", cnt_of(2), 0);
        for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_res_valid", int'(res_valid[0]), 0);
        run_op(0, 15, 1, 0, 0, 16);
        check("post_rst_count", cnt_of(0), 1);
        run_op(0, 15, 10, 3, 0, 13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
